// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared funct3 codes, LSU state type and defaults
package rv32i_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/rv32i_lsu_align.sv
// rtl/rv32i_lsu_align.sv - byte enables, store lane replication, load extension
// and legality checks for one RV32I load/store access.
module rv32i_lsu_align
   import rv32i_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_al,
   output logic [31:0] rdata_ext,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // funct3[1:0] encodes the access size for both legal and illegal codes
   always_comb begin
      be         = 4'hF;
      wdata_al   = wdata;
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            be       = 4'b0001 << addr_lo;
            wdata_al = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << addr_lo;
            wdata_al   = {2{wdata[15:0]}};
            misaligned = addr_lo[0];
         end
         default: misaligned = (addr_lo != 2'b00);
      endcase
   end

   always_comb begin
      if (we)
         illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      else
         illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   end

   always_comb begin
      rbyte = rdata[{addr_lo, 3'b000} +: 8];
      rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
         F3_BU:   rdata_ext = {24'h0, rbyte};
         F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
         F3_HU:   rdata_ext = {16'h0, rhalf};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - RV32I load/store unit: ready/valid bus master with
// wait states, timeout, bus error and misalignment handling.
module rv32i_lsu
   import rv32i_pkg::*;
#(
   parameter int          ADDR_W      = 32,
   parameter int          TIMEOUT_CYC = 16,
   parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              bus_valid,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ready,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_err
);

   localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TLIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [TW-1:0] TLIM_V = TW'(TLIM);

   lsu_state_t  state;
   logic [2:0]  f3_q;
   logic [1:0]  addr_lo_q;
   logic        we_q;
   logic [TW-1:0] tcnt;

   logic        a_we;
   logic [2:0]  a_f3;
   logic [1:0]  a_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misaligned;
   logic        al_illegal;
   logic        timeout_hit;

   // Request fields steer the aligner while idle; captured fields afterwards
   assign a_we = (state == IDLE) ? req_we         : we_q;
   assign a_f3 = (state == IDLE) ? req_funct3     : f3_q;
   assign a_lo = (state == IDLE) ? req_addr[1:0]  : addr_lo_q;

   rv32i_lsu_align u_align (
      .we         (a_we),
      .funct3     (a_f3),
      .addr_lo    (a_lo),
      .wdata      (req_wdata),
      .rdata      (bus_rdata),
      .be         (al_be),
      .wdata_al   (al_wdata),
      .rdata_ext  (al_rdata),
      .misaligned (al_misaligned),
      .illegal    (al_illegal)
   );

   assign req_ready   = (state == IDLE);
   assign stall       = ((state == IDLE) && req_valid) || (state == BUS);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (tcnt == TLIM_V);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         f3_q      <= 3'b000;
         addr_lo_q <= 2'b00;
         we_q      <= 1'b0;
         tcnt      <= '0;
         bus_valid <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= 4'h0;
         bus_wdata <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  f3_q      <= req_funct3;
                  addr_lo_q <= req_addr[1:0];
                  we_q      <= req_we;
                  tcnt      <= '0;
                  bus_we    <= req_we;
                  bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                  bus_be    <= al_be;
                  bus_wdata <= req_we ? al_wdata : 32'h0;
                  if (al_misaligned || al_illegal) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= ERR_RDATA;
                  end else begin
                     state     <= BUS;
                     bus_valid <= 1'b1;
                  end
               end
            end
            BUS: begin
               // a completion on the timeout cycle still counts as success
               if (bus_ready) begin
                  state     <= RESP;
                  bus_valid <= 1'b0;
                  tcnt      <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= bus_err;
                  rsp_rdata <= bus_err ? ERR_RDATA : (we_q ? 32'h0 : al_rdata);
               end else if (timeout_hit) begin
                  state     <= RESP;
                  bus_valid <= 1'b0;
                  tcnt      <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= ERR_RDATA;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - scoreboard bench for rv32i_lsu with a reference model
module tb_rv32i_lsu;

   localparam int          TO   = 4;
   localparam logic [31:0] ERRV = 32'hBAD0_0BAD;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_err = 1'b0;

   rv32i_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO), .ERR_RDATA(ERRV)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acc;
      int          lat;
   } rsp_t;

   typedef struct {
      int          wait_cyc;
      logic [31:0] rdata;
      logic        berr;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } plan_t;

   rsp_t  rq[$];
   plan_t bq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: access size, legality and lane picture from the ISA rules
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int w, input logic [31:0] rd,
                                 input logic berr, output rsp_t r, output plan_t p, output bit has_bus);
      int     nbytes;
      int     off;
      bit     legal;
      bit     sgn;
      longint v;
      off    = int'(addr % 4);
      legal  = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      sgn    = (f3 < 4);
      has_bus = legal && (off % nbytes == 0);
      p.wait_cyc = w;
      p.rdata    = rd;
      p.berr     = berr;
      p.we       = we;
      p.addr     = addr - 32'(off);
      p.be       = 4'(((1 << nbytes) - 1) << off);
      for (int i = 0; i < 4; i++) p.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      r.acc = 0;
      if (!has_bus) begin
         r.err = 1'b1; r.rdata = ERRV; r.lat = 1;
      end else if (w >= TO) begin
         r.err = 1'b1; r.rdata = ERRV; r.lat = TO + 1;
      end else begin
         r.lat = w + 2;
         if (berr) begin
            r.err = 1'b1; r.rdata = ERRV;
         end else if (we) begin
            r.err = 1'b0; r.rdata = 32'h0;
         end else begin
            v = {32'h0, rd};
            v = (v >> (8 * off)) & ((64'sd1 <<< (8 * nbytes)) - 1);
            if (sgn && nbytes < 4 && v >= (64'sd1 <<< (8 * nbytes - 1)))
               v = v - (64'sd1 <<< (8 * nbytes));
            r.err = 1'b0; r.rdata = v[31:0];
         end
      end
   endfunction

   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int w, input logic [31:0] rd,
                       input logic berr, input int gap);
      rsp_t  r;
      plan_t p;
      bit    hb;
      int    guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      #1;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      chk("req_accept", req_ready, 1'b1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      chk("stall_on_req", stall, 1'b1);
      model(we, f3, addr, wd, w, rd, berr, r, p, hb);
      r.acc = cyc;
      if (hb) bq.push_back(p);
      rq.push_back(r);
      @(posedge clk); #1;
      if (gap > 0) begin
         req_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic chk_bus(input plan_t p, input string tag);
      chk({tag, "_addr"}, bus_addr, p.addr);
      chk({tag, "_be"}, bus_be, p.be);
      chk({tag, "_we"}, bus_we, p.we);
      if (p.we) chk({tag, "_wdata"}, bus_wdata, p.wdata);
   endtask

   // Bus responder: checks the presented access and plays back the planned timing
   initial begin
      plan_t p;
      forever begin
         @(negedge clk);
         if (bus_valid && reset) begin
            if (bq.size() == 0) begin
               chk("bus_unexpected", bus_valid, 1'b0);
            end else begin
               p = bq.pop_front();
               chk_bus(p, "bus");
               if (p.wait_cyc >= TO) begin
                  repeat (TO - 1) begin
                     @(negedge clk);
                     chk("bus_hold_valid", bus_valid, 1'b1);
                     chk_bus(p, "bus_hold");
                  end
                  @(negedge clk);
                  chk("timeout_drop", bus_valid, 1'b0);
               end else if (p.wait_cyc >= 0) begin
                  repeat (p.wait_cyc) begin
                     @(negedge clk);
                     chk("bus_hold_valid", bus_valid, 1'b1);
                     chk_bus(p, "bus_hold");
                  end
                  bus_ready = 1'b1; bus_rdata = p.rdata; bus_err = p.berr;
                  @(negedge clk);
                  bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
                  chk("bus_drop", bus_valid, 1'b0);
               end
            end
         end
      end
   end

   // Response monitor
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
               r = rq.pop_front();
               chk("rsp_err", rsp_err, r.err);
               chk("rsp_rdata", rsp_rdata, r.rdata);
               chk("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
               chk("rsp_stall_low", stall, 1'b0);
            end
         end
      end
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      rsp_t  r;
      plan_t p;
      bit    hb;
      int    guard;
      int    w;
      #12;
      chk("rst_bus_valid", bus_valid, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_be", bus_be, 4'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_req_ready", req_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;

      send(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 2);
      send(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000, 1'b0, 1);
      send(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000, 1'b0, 1);
      send(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1, 32'h0, 1'b0, 1);
      send(1'b0, 3'b001, 32'h0000_0101, 32'h0, 0, 32'h0, 1'b0, 1);
      send(1'b0, 3'b010, 32'h0000_0104, 32'h0, TO, 32'h0, 1'b0, 1);
      send(1'b0, 3'b010, 32'h0000_0108, 32'h0, 1, 32'h1234_5678, 1'b1, 1);
      send(1'b0, 3'b010, 32'h0000_0108, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 0);
      send(1'b1, 3'b010, 32'h0000_010C, 32'hA5A5_5A5A, 3, 32'h0, 1'b0, 2);
      send(1'b1, 3'b011, 32'h0000_0110, 32'h0, 0, 32'h0, 1'b0, 0);
      send(1'b0, 3'b110, 32'h0000_0110, 32'h0, 0, 32'h0, 1'b0, 1);

      for (int n = 0; n < 300; n++) begin
         w = ($urandom % 8 == 0) ? TO + int'($urandom % 3) : int'($urandom_range(0, 3));
         send(1'($urandom), 3'($urandom), $urandom, $urandom, w, $urandom,
              1'($urandom % 6 == 0), int'($urandom_range(0, 3)));
      end

      guard = 0;
      while ((rq.size() != 0 || bq.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_rsp_queue", 32'(rq.size()), 32'h0);
      chk("drain_bus_queue", 32'(bq.size()), 32'h0);

      // Reset while the bus access is outstanding
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0200;
      #1;
      chk("rstbus_accept", req_ready, 1'b1);
      model(1'b0, 3'b010, 32'h0000_0200, 32'h0, -1, 32'h0, 1'b0, r, p, hb);
      bq.push_back(p);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); #1;
      chk("rstbus_valid_before", bus_valid, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("rstbus_async_drop", bus_valid, 1'b0);
      chk("rstbus_no_rsp", rsp_valid, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rstbus_req_ready", req_ready, 1'b1);
      chk("rstbus_bus_idle", bus_valid, 1'b0);
      repeat (4) @(negedge clk);
      chk("final_rsp_queue", 32'(rq.size()), 32'h0);
      chk("final_bus_queue", 32'(bq.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
